counter_display_driver: RTL and testbench
=========================================

// Module: counter_display_driver
// PURPOSE
//  Downstream consumer of the N-bit up/down counter: takes its count value and threshold flag.
//  Converts the count to BCD with a sequential double-dabble engine.
//  Drives a time-multiplexed, active-low 7-segment display (Nexys-style, common anode).
//  Blinks the display while the counter's threshold flag is high.
// PARAMETERS
//  N            32          width of value_in (counter width)
//  DIGITS       8           number of BCD digits / display positions
//  REFRESH_DIV  100_000     clock cycles per digit slot (1 kHz at 100 MHz)
//  BLINK_DIV    50_000_000  clock cycles per blink half-period
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low; all state cleared while low
//  value_in   in   N       unsigned count from the counter stage
//  threshold  in   1       threshold flag from the counter stage; enables blinking
//  segments   out  7       {g,f,e,d,c,b,a}, active-low
//  dp         out  1       decimal point, active-low; held 1 (off)
//  anodes     out  DIGITS  digit enables, active-low; at most one low at any time
//  busy       out  1       1 while a conversion is in progress
//  overflow   out  1       1 if the displayed value did not fit in DIGITS decimal digits
// BEHAVIOUR
//  Reset (reset=0), values forced asynchronously:
//   - FSM=IDLE, busy=0, overflow=0, captured value=0, display BCD=0
//   - scan index=0, refresh count=0, blink count=0, blink phase=0
//   - anodes=~1 (digit 0 on), segments show "0", dp=1
//  FSM:
//   - IDLE: if value_in != captured, capture value_in into the shift register and captured,
//     clear the BCD work register, go to CONV. Otherwise stay in IDLE.
//   - CONV: exactly N cycles, one per input bit, MSB first.
//     Each cycle: every work digit >= 5 gets +3, then {work,shift} shifts left by 1.
//     A 1 shifted out of the top work digit sets a sticky ovf_work bit.
//   - LOAD: display BCD <= work, overflow <= ovf_work, return to IDLE.
//   - busy=1 in CONV and LOAD.
//  Latency: value captured at edge t -> display/overflow updated at edge t+N+1.
//   IDLE re-checks for a change on the next cycle.
//  Changes on value_in during CONV/LOAD are ignored. The final value is picked up by the
//   IDLE compare after LOAD, so the display converges to the last stable value.
//  Overflow: display shows value mod 10^DIGITS; overflow=1 until a fitting value is converted.
//  Scan:
//   - Refresh counter wraps at REFRESH_DIV-1; on wrap, scan index increments.
//   - Scan index wraps DIGITS-1 -> 0.
//   - anodes = ~(1 << index).
//   - segments = decode(display digit[index]).
//  Decode table:
//   - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
//   - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
//   - blank (and any code >9) = 1111111
//  Leading-zero blanking: digit i>0 is blank when display digits i..DIGITS-1 are all 0.
//   Digit 0 is never blanked.
//  Blink:
//   - While threshold=1: blink counter wraps at BLINK_DIV-1 and toggles phase on each wrap.
//   - While threshold=0: counter and phase are cleared to 0.
//   - phase=1 forces anodes to all 1s. Scan and conversion continue unaffected.
//  Reset low mid-CONV aborts the conversion. After release, captured=0, so a nonzero
//   value_in starts a fresh conversion on the first cycle.
//  All outputs are registered. segments and anodes update on the same edge (no ghosting).
// TESTING (bench uses N=8, DIGITS=3, REFRESH_DIV=4, BLINK_DIV=16)
//  1. Reset low, value_in=0 -> anodes=3'b110, segments=1000000, busy=0, overflow=0.
//  2. value_in 0->8'd137 -> busy=1 for 9 cycles; after that, digits {1,3,7} scan every
//     4 cycles on anodes 110,101,011 with segments 1111000,0110000,1111001.
//  3. value_in=8'd5 after 137 -> digit0 shows 0010010; digits 1,2 blank (1111111).
//  4. Bench with DIGITS=2: value_in=8'd255 -> shows "55", overflow=1.
//     Then value_in=8'd42 -> overflow=0 and shows "42".
//  5. threshold=1 for 64 cycles -> anodes all 1 for cycles 16-31 and 48-63.
//     threshold=0 -> scanning is visible on the next cycle.
//  6. Change value_in mid-CONV (137 -> 200 at cycle 3) -> display shows 137, then 200
//     N+2 cycles after LOAD. Reset pulse mid-CONV -> immediate "0", then reconversion.

Source files
------------

// File: rtl/counter_display_driver_if.sv
// Bundle between the counter stage and the display driver: count/flag in,
// multiplexed 7-segment drive and conversion status out.
interface counter_display_driver_if #(
  parameter int N      = 32,
  parameter int DIGITS = 8
);
  logic [N-1:0]      value_in;
  logic              threshold;
  logic [6:0]        segments;
  logic              dp;
  logic [DIGITS-1:0] anodes;
  logic              busy;
  logic              overflow;

  modport master (
    output value_in, threshold,
    input  segments, dp, anodes, busy, overflow
  );

  modport slave (
    input  value_in, threshold,
    output segments, dp, anodes, busy, overflow
  );
endinterface

// File: rtl/counter_display_driver.sv
// Sequential double-dabble BCD conversion of the counter value, driving a
// time-multiplexed common-anode 7-segment display that blinks on threshold.
module counter_display_driver #(
  parameter int N           = 32,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 50_000_000
) (
  input logic                     clock,
  input logic                     reset,
  counter_display_driver_if.slave bus
);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int KW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int WW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] SEL0      = DIGITS'(1'b1);
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;
  localparam logic [6:0]        SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Digit i>0 is blanked when it and every more significant digit are zero.
  function automatic logic [6:0] seg_for(input logic [WW-1:0] bcd, input logic [IW-1:0] idx);
    logic       nonzero;
    logic [3:0] d;
    logic [6:0] s;
    nonzero = 1'b0;
    d       = 4'd0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx) d = bcd[4*j +: 4];
      if ((j >= int'(idx)) && (bcd[4*j +: 4] != 4'd0)) nonzero = 1'b1;
    end
    if ((idx == {IW{1'b0}}) || nonzero) s = decode(d);
    else                                s = SEG_BLANK;
    return s;
  endfunction

  state_t            state_r, state_nx_s;
  logic [N-1:0]      captured_r, shift_r;
  logic [WW-1:0]     work_r, work_adj_s, disp_r, disp_nx_s;
  logic              ovf_work_r, overflow_r, overflow_nx_s;
  logic [BW-1:0]     bit_cnt_r;
  logic              capture_s, conv_s, load_s;
  logic              busy_r, dp_r;
  logic [IW-1:0]     scan_idx_r, scan_idx_nx_s;
  logic [RW-1:0]     refresh_cnt_r, refresh_cnt_nx_s;
  logic [KW-1:0]     blink_cnt_r, blink_cnt_nx_s;
  logic              blink_phase_r, blink_phase_nx_s;
  logic [6:0]        segments_r;
  logic [DIGITS-1:0] anodes_r;

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.value_in != captured_r) state_nx_s = CONV;
        else                            state_nx_s = IDLE;
      end
      CONV: begin
        if (bit_cnt_r == BW'(N - 1)) state_nx_s = LOAD;
        else                         state_nx_s = CONV;
      end
      LOAD:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM datapath controls
  always_comb begin
    capture_s = 1'b0;
    conv_s    = 1'b0;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.value_in != captured_r) capture_s = 1'b1;
        else                            capture_s = 1'b0;
      end
      CONV:    conv_s = 1'b1;
      LOAD:    load_s = 1'b1;
      default: capture_s = 1'b0;
    endcase
  end

  // Add-3 correction on every work digit before the shift
  always_comb begin
    work_adj_s = work_r;
    for (int i = 0; i < DIGITS; i++) begin
      work_adj_s[4*i +: 4] = (work_r[4*i +: 4] >= 4'd5) ? (work_r[4*i +: 4] + 4'd3)
                                                          : work_r[4*i +: 4];
    end
  end

  // Conversion engine: capture, then N shift steps MSB first
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      captured_r <= {N{1'b0}};
      shift_r    <= {N{1'b0}};
      work_r     <= {WW{1'b0}};
      ovf_work_r <= 1'b0;
      bit_cnt_r  <= {BW{1'b0}};
    end else if (capture_s) begin
      captured_r <= bus.value_in;
      shift_r    <= bus.value_in;
      work_r     <= {WW{1'b0}};
      ovf_work_r <= 1'b0;
      bit_cnt_r  <= {BW{1'b0}};
    end else if (conv_s) begin
      {work_r, shift_r} <= {work_adj_s[WW-2:0], shift_r, 1'b0};
      ovf_work_r        <= ovf_work_r | work_adj_s[WW-1];
      bit_cnt_r         <= bit_cnt_r + BW'(1'b1);
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Next display contents, scan position and blink phase
  always_comb begin
    disp_nx_s     = load_s ? work_r : disp_r;
    overflow_nx_s = load_s ? ovf_work_r : overflow_r;
    if (refresh_cnt_r == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt_nx_s = {RW{1'b0}};
      if (scan_idx_r == IW'(DIGITS - 1)) scan_idx_nx_s = {IW{1'b0}};
      else                               scan_idx_nx_s = scan_idx_r + IW'(1'b1);
    end else begin
      refresh_cnt_nx_s = refresh_cnt_r + RW'(1'b1);
      scan_idx_nx_s    = scan_idx_r;
    end
    if (!bus.threshold) begin
      blink_cnt_nx_s   = {KW{1'b0}};
      blink_phase_nx_s = 1'b0;
    end else if (blink_cnt_r == KW'(BLINK_DIV - 1)) begin
      blink_cnt_nx_s   = {KW{1'b0}};
      blink_phase_nx_s = ~blink_phase_r;
    end else begin
      blink_cnt_nx_s   = blink_cnt_r + KW'(1'b1);
      blink_phase_nx_s = blink_phase_r;
    end
  end

  // Display state and registered outputs; segments/anodes from the same next-state values
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_r        <= {WW{1'b0}};
      overflow_r    <= 1'b0;
      busy_r        <= 1'b0;
      dp_r          <= 1'b1;
      scan_idx_r    <= {IW{1'b0}};
      refresh_cnt_r <= {RW{1'b0}};
      blink_cnt_r   <= {KW{1'b0}};
      blink_phase_r <= 1'b0;
      anodes_r      <= ~SEL0;
      segments_r    <= SEG_ZERO;
    end else begin
      disp_r        <= disp_nx_s;
      overflow_r    <= overflow_nx_s;
      busy_r        <= (state_nx_s != IDLE);
      dp_r          <= 1'b1;
      scan_idx_r    <= scan_idx_nx_s;
      refresh_cnt_r <= refresh_cnt_nx_s;
      blink_cnt_r   <= blink_cnt_nx_s;
      blink_phase_r <= blink_phase_nx_s;
      anodes_r      <= blink_phase_nx_s ? {DIGITS{1'b1}} : ~(SEL0 << scan_idx_nx_s);
      segments_r    <= seg_for(disp_nx_s, scan_idx_nx_s);
    end
  end

  assign bus.segments = segments_r;
  assign bus.anodes   = anodes_r;
  assign bus.dp       = dp_r;
  assign bus.busy     = busy_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_counter_display_driver.sv
// Directed bench for counter_display_driver: a 3-digit and a 2-digit instance
// with fast refresh/blink dividers.
module tb_counter_display_driver;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [6:0] seen3 [3];
  int         hits3 [3];
  int         stray3;
  logic [6:0] seen2 [2];
  int         hits2 [2];
  int         stray2;

  counter_display_driver_if #(.N(8), .DIGITS(3)) bus3 ();
  counter_display_driver_if #(.N(8), .DIGITS(2)) bus2 ();

  counter_display_driver #(.N(8), .DIGITS(3), .REFRESH_DIV(4), .BLINK_DIV(16)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3)
  );
  counter_display_driver #(.N(8), .DIGITS(2), .REFRESH_DIV(4), .BLINK_DIV(16)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counts busy-high samples after new stimulus until busy drops (bounded).
  task automatic wait_conv(input bit two, output int cycles);
    logic b;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      b = two ? bus2.busy : bus3.busy;
      if (b) cycles++;
      else if (cycles > 0) break;
    end
  endtask

  // Records which segment pattern appears on each anode over one full scan period.
  task automatic sample_scan3();
    int idx;
    for (int k = 0; k < 3; k++) begin hits3[k] = 0; seen3[k] = 7'h00; end
    stray3 = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      case (bus3.anodes)
        3'b110:  idx = 0;
        3'b101:  idx = 1;
        3'b011:  idx = 2;
        default: idx = -1;
      endcase
      if (idx < 0) stray3++;
      else begin
        if (hits3[idx] > 0 && seen3[idx] !== bus3.segments) stray3++;
        seen3[idx] = bus3.segments;
        hits3[idx]++;
      end
    end
  endtask

  task automatic sample_scan2();
    int idx;
    for (int k = 0; k < 2; k++) begin hits2[k] = 0; seen2[k] = 7'h00; end
    stray2 = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      case (bus2.anodes)
        2'b10:   idx = 0;
        2'b01:   idx = 1;
        default: idx = -1;
      endcase
      if (idx < 0) stray2++;
      else begin
        if (hits2[idx] > 0 && seen2[idx] !== bus2.segments) stray2++;
        seen2[idx] = bus2.segments;
        hits2[idx]++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus3.value_in = 8'd0; bus3.threshold = 1'b0;
    bus2.value_in = 8'd0; bus2.threshold = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus3.anodes !== 3'b110) begin errors++; $display("FAIL rst_anodes: got %b want 110", bus3.anodes); end
    checks++; if (bus3.segments !== 7'b1000000) begin errors++; $display("FAIL rst_segments: got %b want 1000000", bus3.segments); end
    checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus3.busy); end
    checks++; if (bus3.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", bus3.overflow); end
    checks++; if (bus3.dp !== 1'b1) begin errors++; $display("FAIL rst_dp: got %b want 1", bus3.dp); end
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus3.busy); end
  endtask

  task automatic test_convert();
    int cyc;
    bus3.value_in = 8'd137;
    wait_conv(1'b0, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL conv_busy_len: got %0d want 9", cyc); end
    checks++; if (bus3.overflow !== 1'b0) begin errors++; $display("FAIL conv_overflow: got %b want 0", bus3.overflow); end
    sample_scan3();
    checks++; if (stray3 !== 0 || hits3[0] !== 4 || hits3[1] !== 4 || hits3[2] !== 4) begin
      errors++; $display("FAIL conv_scan: stray %0d hits %0d/%0d/%0d want 0 and 4/4/4", stray3, hits3[0], hits3[1], hits3[2]);
    end
    checks++; if (seen3[0] !== 7'b1111000) begin errors++; $display("FAIL conv_d0: got %b want 1111000", seen3[0]); end
    checks++; if (seen3[1] !== 7'b0110000) begin errors++; $display("FAIL conv_d1: got %b want 0110000", seen3[1]); end
    checks++; if (seen3[2] !== 7'b1111001) begin errors++; $display("FAIL conv_d2: got %b want 1111001", seen3[2]); end
  endtask

  task automatic test_blanking();
    int cyc;
    bus3.value_in = 8'd5;
    wait_conv(1'b0, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL blank_busy_len: got %0d want 9", cyc); end
    sample_scan3();
    checks++; if (stray3 !== 0) begin errors++; $display("FAIL blank_scan: stray %0d want 0", stray3); end
    checks++; if (seen3[0] !== 7'b0010010) begin errors++; $display("FAIL blank_d0: got %b want 0010010", seen3[0]); end
    checks++; if (seen3[1] !== 7'b1111111) begin errors++; $display("FAIL blank_d1: got %b want 1111111", seen3[1]); end
    checks++; if (seen3[2] !== 7'b1111111) begin errors++; $display("FAIL blank_d2: got %b want 1111111", seen3[2]); end
  endtask

  task automatic test_overflow();
    int cyc;
    bus2.value_in = 8'd255;
    wait_conv(1'b1, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL ovf_busy_len: got %0d want 9", cyc); end
    checks++; if (bus2.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus2.overflow); end
    sample_scan2();
    checks++; if (stray2 !== 0 || hits2[0] !== 4 || hits2[1] !== 4) begin
      errors++; $display("FAIL ovf_scan: stray %0d hits %0d/%0d want 0 and 4/4", stray2, hits2[0], hits2[1]);
    end
    checks++; if (seen2[0] !== 7'b0010010) begin errors++; $display("FAIL ovf_d0: got %b want 0010010", seen2[0]); end
    checks++; if (seen2[1] !== 7'b0010010) begin errors++; $display("FAIL ovf_d1: got %b want 0010010", seen2[1]); end
    bus2.value_in = 8'd42;
    wait_conv(1'b1, cyc);
    checks++; if (bus2.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus2.overflow); end
    sample_scan2();
    checks++; if (seen2[0] !== 7'b0100100) begin errors++; $display("FAIL fit_d0: got %b want 0100100", seen2[0]); end
    checks++; if (seen2[1] !== 7'b0011001) begin errors++; $display("FAIL fit_d1: got %b want 0011001", seen2[1]); end
  endtask

  task automatic test_blink();
    int bad;
    int first_bad;
    bit exp_blank;
    bad = 0; first_bad = -1;
    bus3.threshold = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clock); #1;
      exp_blank = (((c / 16) % 2) == 1);
      if (exp_blank ? (bus3.anodes !== 3'b111) : ($countones(~bus3.anodes) != 1)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL blink_pattern: %0d bad cycles (first %0d) want 0", bad, first_bad); end
    bus3.threshold = 1'b0;
    @(posedge clock); #1;
    checks++; if ($countones(~bus3.anodes) != 1) begin errors++; $display("FAIL blink_release: got anodes %b want one low", bus3.anodes); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [6:0] exp_seg;
    bus3.value_in = 8'd137;
    repeat (3) begin @(posedge clock); #1; end
    bus3.value_in = 8'd200;
    wait_conv(1'b0, cyc);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL b2b_first_len: got %0d want 6", cyc); end
    case (bus3.anodes)
      3'b110:  exp_seg = 7'b1111000;
      3'b101:  exp_seg = 7'b0110000;
      3'b011:  exp_seg = 7'b1111001;
      default: exp_seg = 7'bxxxxxxx;
    endcase
    checks++; if (bus3.segments !== exp_seg) begin errors++; $display("FAIL b2b_shows_137: got %b want %b", bus3.segments, exp_seg); end
    wait_conv(1'b0, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL b2b_second_len: got %0d want 9", cyc); end
    sample_scan3();
    checks++; if (seen3[0] !== 7'b1000000 || seen3[1] !== 7'b1000000 || seen3[2] !== 7'b0100100) begin
      errors++; $display("FAIL b2b_shows_200: got %b/%b/%b want 1000000/1000000/0100100", seen3[0], seen3[1], seen3[2]);
    end
    // Reset in the middle of a conversion, then reconvert after release.
    bus3.value_in = 8'd99;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    checks++; if (bus3.anodes !== 3'b110 || bus3.segments !== 7'b1000000) begin
      errors++; $display("FAIL midrst_display: got %b/%b want 110/1000000", bus3.anodes, bus3.segments);
    end
    checks++; if (bus3.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus3.busy); end
    @(negedge clock); reset = 1'b1;
    wait_conv(1'b0, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL midrst_reconv_len: got %0d want 9", cyc); end
    sample_scan3();
    checks++; if (seen3[0] !== 7'b0010000 || seen3[1] !== 7'b0010000 || seen3[2] !== 7'b1111111) begin
      errors++; $display("FAIL midrst_shows_99: got %b/%b/%b want 0010000/0010000/1111111", seen3[0], seen3[1], seen3[2]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    @(posedge clock); #1;
    test_convert();
    test_blanking();
    test_overflow();
    test_blink();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
